// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch sequencer: drives NPC/PCWrite for a word-addressed PC
// register, issues instruction-memory requests at the current PC, waits on a
// variable-latency memory, applies redirects and stalls, and retries a fetch
// that times out.
module if_fetch_ctrl #(
  parameter logic [29:0] START_ADDR = 30'h0000BFF,
  parameter logic [29:0] EXC_VECTOR = 30'h0000C00,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] pc,
  input  logic        stall,
  input  logic        exc,
  input  logic        br_taken,
  input  logic [29:0] br_target,
  input  logic        jmp,
  input  logic [29:0] jmp_target,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  output logic [29:0] npc,
  output logic        pc_write,
  output logic        if_valid,
  output logic        if_flush,
  output logic        timeout_err
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [29:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]  pend_prio_q, pend_prio_d;

  logic        redir;
  logic [29:0] redir_tgt;
  logic [1:0]  redir_prio;
  logic        active, complete, tmo, apply, latch;
  logic [29:0] apply_tgt;

  // Redirect selection: exception beats branch beats jump; rank kept so a
  // pending redirect is only replaced by one of equal or higher rank.
  always_comb begin
    redir      = exc | br_taken | jmp;
    redir_tgt  = '0;
    redir_prio = 2'd0;
    if (exc) begin
      redir_tgt  = EXC_VECTOR;
      redir_prio = 2'd3;
    end else if (br_taken) begin
      redir_tgt  = br_target;
      redir_prio = 2'd2;
    end else if (jmp) begin
      redir_tgt  = jmp_target;
      redir_prio = 2'd1;
    end
  end

  // Cycle classification and all combinational outputs.
  always_comb begin
    active    = !reset && (state_q != S_BOOT);
    complete  = active && imem_ready;
    tmo       = !reset && (state_q == S_WAIT) && !imem_ready && (cnt_q == TMO);
    // A live redirect always wins over one remembered from earlier.
    apply     = (complete || tmo) && (redir || pend_q);
    apply_tgt = redir ? redir_tgt : pend_tgt_q;
    // Redirects arriving while a request is still outstanding are remembered
    // so the address presented to memory never moves mid-request.
    latch     = active && !imem_ready && !tmo && redir &&
                (!pend_q || (redir_prio >= pend_prio_q));

    imem_req    = active;
    imem_addr   = pc;
    if_flush    = apply;
    timeout_err = tmo;
    if_valid    = complete && !redir && !pend_q && !stall;
    pc_write    = apply || if_valid;
    if (!active)   npc = START_ADDR;
    else if (apply) npc = apply_tgt;
    else            npc = pc + 30'd1;
  end

  // Next-state logic for the fetch FSM, wait counter and pending redirect.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_tgt_d  = pend_tgt_q;
    pend_prio_d = pend_prio_q;
    if (latch) begin
      pend_d      = 1'b1;
      pend_tgt_d  = redir_tgt;
      pend_prio_d = redir_prio;
    end
    unique case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (!imem_ready) begin
          state_d = S_WAIT;
          cnt_d   = 8'd1;
        end
      end
      S_WAIT: begin
        if (imem_ready || tmo) begin
          state_d = S_FETCH;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_BOOT;
    endcase
    if (complete || tmo) begin
      pend_d      = 1'b0;
      pend_prio_d = 2'd0;
    end
  end

  // State registers with synchronous reset back to BOOT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_BOOT;
      cnt_q       <= 8'd0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
      pend_prio_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_tgt_q  <= pend_tgt_d;
      pend_prio_q <= pend_prio_d;
    end
  end

endmodule
